// File: rtl/alu_ctl_seq.sv
// alu_ctl_seq: multicycle ALU control sequencer.
// Accepts an R-type funct code and a shift amount over a valid/ready handshake,
// drives a registered ALU op code and sequences the iterative ops (MULTU, SRL)
// with a down-counter and per-cycle step strobes.
// Optional feature macro: ALU_CTL_DIVU_EN (makes funct 27, DIVU, a legal
// WIDTH-step iterative op that writes HI/LO on completion).
module alu_ctl_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic [5:0]         ctl,
    output logic               iter_step,
    output logic               hilo_we,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   count
);

    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH - 1);
    localparam logic [31:0]      WIDTH_U  = 32'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Codes the sequencer knows how to run; anything else takes the error path.
    function automatic logic is_legal(input logic [5:0] f);
        logic ok;
        case (f)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MULTU: ok = 1'b1;
`ifdef ALU_CTL_DIVU_EN
            F_DIVU:                                          ok = 1'b1;
`endif
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Full-width iterative ops: run WIDTH steps and write HI/LO when finished.
    function automatic logic is_hilo_op(input logic [5:0] f);
        logic hit;
        case (f)
            F_MULTU: hit = 1'b1;
`ifdef ALU_CTL_DIVU_EN
            F_DIVU:  hit = 1'b1;
`endif
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    state_t           state_q, state_d;
    logic [5:0]       ctl_q, ctl_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             iter_step_q, iter_step_d;
    logic             hilo_we_q, hilo_we_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      shamt_ext_s;
    logic [31:0]      shamt_clamp_s;

    // Shift steps never exceed the datapath width.
    always_comb begin
        shamt_ext_s = 32'(shamt);
        if (shamt_ext_s > WIDTH_U) begin
            shamt_clamp_s = WIDTH_U;
        end else begin
            shamt_clamp_s = shamt_ext_s;
        end
    end

    // Next-state, op-code latch and counter logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        ctl_d   = ctl_q;
        count_d = count_q;
        err_d   = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            ctl_d   = 6'd0;
            count_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!is_legal(funct)) begin
                            state_d = S_EXEC;
                            ctl_d   = 6'd0;
                            err_d   = 1'b1;
                        end else if (is_hilo_op(funct)) begin
                            state_d = S_ITER;
                            ctl_d   = funct;
                            count_d = CNT_FULL;
                        end else if ((funct == F_SRL) && (shamt_clamp_s != 32'd0)) begin
                            state_d = S_ITER;
                            ctl_d   = funct;
                            count_d = CNT_W'(shamt_clamp_s - 32'd1);
                        end else begin
                            state_d = S_EXEC;
                            ctl_d   = funct;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_EXEC: begin
                    state_d = S_IDLE;
                    ctl_d   = 6'd0;
                    count_d = {CNT_W{1'b0}};
                end
                S_ITER: begin
                    if (count_q == {CNT_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    ctl_d   = 6'd0;
                    count_d = {CNT_W{1'b0}};
                end
                default: begin
                    state_d = S_IDLE;
                    ctl_d   = 6'd0;
                    count_d = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Strobes decoded from the next state so they register in step with it.
    always_comb begin
        iter_step_d = (state_d == S_ITER);
        done_d      = (state_d == S_EXEC) || (state_d == S_DONE);
        hilo_we_d   = (state_d == S_DONE) && is_hilo_op(ctl_d);
    end

    // State, op code, counter and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ctl_q       <= 6'd0;
            count_q     <= {CNT_W{1'b0}};
            iter_step_q <= 1'b0;
            hilo_we_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctl_q       <= ctl_d;
            count_q     <= count_d;
            iter_step_q <= iter_step_d;
            hilo_we_q   <= hilo_we_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign ctl       = ctl_q;
    assign count     = count_q;
    assign iter_step = iter_step_q;
    assign hilo_we   = hilo_we_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Self-checking bench for alu_ctl_seq (WIDTH=32): directed stimulus pushes the
// expected completion into a queue; a monitor pops it on every done pulse.
module tb_alu_ctl_seq;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int CNT_W   = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [5:0]         funct = 6'd0;
    logic [SHAMT_W-1:0] shamt = '0;
    logic               flush = 1'b0;
    logic [5:0]         ctl;
    logic               iter_step;
    logic               hilo_we;
    logic               done;
    logic               err;
    logic [CNT_W-1:0]   count;

    alu_ctl_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .shamt(shamt), .flush(flush), .ctl(ctl),
        .iter_step(iter_step), .hilo_we(hilo_we), .done(done), .err(err),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] ctl;
        logic       err;
        logic       hilo;
        int         steps;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [5:0] c, input logic e, input logic h, input int s);
        exp_t x;
        x.ctl = c; x.err = e; x.hilo = h; x.steps = s;
        exp_q.push_back(x);
    endtask

    // Monitor: counts step strobes and checks each completion against the queue.
    initial begin
        int   steps;
        exp_t e;
        steps = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || flush) begin
                steps = 0;
            end else begin
                if (iter_step) steps++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mon_unexpected_done actual=1 required=0 ctl=%0d", ctl);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mon_ctl", 32'(ctl), 32'(e.ctl));
                        chk("mon_err", 32'(err), 32'(e.err));
                        chk("mon_hilo_we", 32'(hilo_we), 32'(e.hilo));
                        chk("mon_steps", 32'(steps), 32'(e.steps));
                    end
                    steps = 0;
                end
            end
        end
    end

    // Advance n clock edges, landing just after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [SHAMT_W-1:0] s);
        logic ok;
        ok = 1'b0;
        funct = f;
        shamt = s;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=0 required=1");
        end
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=0 required=1");
        end
        cyc(1);
    endtask

    logic [5:0] single_ops [4];

    initial begin
        int guard;
        single_ops[0] = 6'd36;
        single_ops[1] = 6'd37;
        single_ops[2] = 6'd34;
        single_ops[3] = 6'd42;

        // Reset held
        cyc(2);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ctl", 32'(ctl), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Reset asserted mid-ITER: no completion expected
        issue(6'd25, '0);
        cyc(5);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_ctl", 32'(ctl), 32'd0);
        chk("midrst_iter_step", 32'(iter_step), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_hilo_we", 32'(hilo_we), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_ctl", 32'(ctl), 32'd0);

        // ADD: single cycle
        push(6'd32, 1'b0, 1'b0, 0);
        issue(6'd32, '0);
        chk("add_ctl", 32'(ctl), 32'd32);
        chk("add_done", 32'(done), 32'd1);
        chk("add_err", 32'(err), 32'd0);
        chk("add_in_ready", 32'(in_ready), 32'd0);
        wait_idle();

        // AND, OR, SUB, SLT
        foreach (single_ops[i]) begin
            push(single_ops[i], 1'b0, 1'b0, 0);
            issue(single_ops[i], 5'd7);
            wait_idle();
        end

        // MULTU cycle-exact
        push(6'd25, 1'b0, 1'b1, 32);
        issue(6'd25, '0);
        for (int i = 0; i < 32; i++) begin
            chk("multu_step", 32'(iter_step), 32'd1);
            chk("multu_count", 32'(count), 32'(31 - i));
            cyc(1);
        end
        chk("multu_done", 32'(done), 32'd1);
        chk("multu_hilo_we", 32'(hilo_we), 32'd1);
        chk("multu_busy_at_done", 32'(in_ready), 32'd0);
        cyc(1);
        chk("multu_ready_after", 32'(in_ready), 32'd1);
        chk("multu_done_cleared", 32'(done), 32'd0);
        chk("multu_ctl_cleared", 32'(ctl), 32'd0);

        // SRL variants
        push(6'd2, 1'b0, 1'b0, 5);
        issue(6'd2, 5'd5);
        chk("srl5_count", 32'(count), 32'd4);
        wait_idle();
        push(6'd2, 1'b0, 1'b0, 0);
        issue(6'd2, 5'd0);
        chk("srl0_done", 32'(done), 32'd1);
        chk("srl0_step", 32'(iter_step), 32'd0);
        wait_idle();
        push(6'd2, 1'b0, 1'b0, 31);
        issue(6'd2, 5'd31);
        wait_idle();

        // Illegal codes
        push(6'd0, 1'b1, 1'b0, 0);
        issue(6'd63, '0);
        chk("ill_done", 32'(done), 32'd1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_ctl", 32'(ctl), 32'd0);
        wait_idle();
`ifdef ALU_CTL_DIVU_EN
        push(6'd27, 1'b0, 1'b1, 32);
`else
        push(6'd0, 1'b1, 1'b0, 0);
`endif
        issue(6'd27, '0);
        wait_idle();

        // Flush mid-ITER at count 10: no completion expected
        issue(6'd25, '0);
        guard = 0;
        while (count != 6'd10 && guard < 100) begin
            cyc(1);
            guard++;
        end
        chk("flush_reached_10", 32'(count), 32'd10);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_step", 32'(iter_step), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_ctl", 32'(ctl), 32'd0);
        cyc(3);

        // Flush with in_valid in IDLE drops the request
        funct = 6'd32;
        in_valid = 1'b1;
        flush = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flushreq_in_ready", 32'(in_ready), 32'd1);
        chk("flushreq_ctl", 32'(ctl), 32'd0);
        chk("flushreq_done", 32'(done), 32'd0);
        cyc(2);

        // in_valid held across MULTU; funct changed mid-ITER
        push(6'd25, 1'b0, 1'b1, 32);
        push(6'd32, 1'b0, 1'b0, 0);
        funct = 6'd25;
        in_valid = 1'b1;
        cyc(1);
        cyc(10);
        funct = 6'd32;
        guard = 0;
        while (!done && guard < 100) begin
            chk("hold_ctl", 32'(ctl), 32'd25);
            chk("hold_busy", 32'(in_ready), 32'd0);
            cyc(1);
            guard++;
        end
        chk("hold_done_seen", 32'(done), 32'd1);
        cyc(1);
        chk("hold_ready_after", 32'(in_ready), 32'd1);
        chk("hold_ctl_idle", 32'(ctl), 32'd0);
        cyc(1);
        in_valid = 1'b0;
        chk("hold_second_ctl", 32'(ctl), 32'd32);
        chk("hold_second_done", 32'(done), 32'd1);
        wait_idle();

        cyc(2);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
